// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order result queue feeding the register file write port.
// Collects ALU and load results, drains one write per cycle from the head, and
// forwards pending values to decode so source reads never observe stale data.
module writeback_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mem_valid,
  input  logic [TAG_WIDTH-1:0]          mem_rd,
  input  logic [WORD_WIDTH-1:0]         mem_value,
  output logic                          mem_ready,
  input  logic                          alu_valid,
  input  logic [TAG_WIDTH-1:0]          alu_rd,
  input  logic [WORD_WIDTH-1:0]         alu_value,
  output logic                          alu_ready,
  output logic                          write_to_rd,
  output logic [TAG_WIDTH-1:0]          rd,
  output logic [WORD_WIDTH-1:0]         rd_value,
  input  logic [TAG_WIDTH-1:0]          rs1,
  input  logic [TAG_WIDTH-1:0]          rs2,
  output logic                          rs1_hit,
  output logic                          rs2_hit,
  output logic [WORD_WIDTH-1:0]         rs1_fwd,
  output logic [WORD_WIDTH-1:0]         rs2_fwd,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [TAG_WIDTH-1:0]  tag_q [DEPTH];
  logic [WORD_WIDTH-1:0] val_q [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  logic [CNT_W-1:0]      free;
  logic                  pop;
  logic                  push_mem;
  logic                  push_alu;
  logic [PTR_W-1:0]      alu_idx;
  logic [PTR_W-1:0]      fwd_idx;

  // Handshake and push/pop decisions; ready depends on registered count only.
  always_comb begin
    free      = CNT_W'(DEPTH) - count;
    mem_ready = ~reset & (free >= CNT_W'(1));
    alu_ready = ~reset & (free >= CNT_W'(2));
    push_mem  = mem_valid & mem_ready & (mem_rd != '0);
    push_alu  = alu_valid & alu_ready & (alu_rd != '0);
    pop       = (count != '0);
    // Load result is the older instruction, so the ALU entry slots in behind it.
    alu_idx   = tail + PTR_W'(push_mem);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(push_mem) + PTR_W'(push_alu);
      count <= count - CNT_W'(pop) + CNT_W'(push_mem) + CNT_W'(push_alu);
    end
  end

  // Entry storage; contents are only meaningful while covered by count.
  always_ff @(posedge clock) begin
    if (push_mem) begin
      tag_q[tail] <= mem_rd;
      val_q[tail] <= mem_value;
    end
    if (push_alu) begin
      tag_q[alu_idx] <= alu_rd;
      val_q[alu_idx] <= alu_value;
    end
  end

  // Register file write port driven straight from the head entry.
  always_comb begin
    write_to_rd = (count != '0);
    rd          = '0;
    rd_value    = '0;
    if (count != '0) begin
      rd       = tag_q[head];
      rd_value = val_q[head];
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    rs1_fwd = '0;
    rs2_fwd = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((rs1 != '0) && (tag_q[fwd_idx] == rs1)) begin
          rs1_hit = 1'b1;
          rs1_fwd = val_q[fwd_idx];
        end
        if ((rs2 != '0) && (tag_q[fwd_idx] == rs2)) begin
          rs2_hit = 1'b1;
          rs2_fwd = val_q[fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed vectors plus multi-cycle sequences for writeback_buffer.
module tb_writeback_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_value;
  logic        mem_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        alu_ready;
  logic        write_to_rd;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_hit;
  logic        rs2_hit;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  writeback_buffer #(.DEPTH(4), .WORD_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_value(mem_value), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value), .alu_ready(alu_ready),
    .write_to_rd(write_to_rd), .rd(rd), .rd_value(rd_value),
    .rs1(rs1), .rs2(rs2), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mval;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] aval;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic [2:0]  e_cnt;
    logic        e_h1;
    logic [31:0] e_f1;
    logic        e_h2;
    logic [31:0] e_f2;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One table row: present inputs for one edge, then inspect the resulting state.
  task automatic apply(input vec_t v, input int k);
    mem_valid = v.mv;  mem_rd = v.mrd;  mem_value = v.mval;
    alu_valid = v.av;  alu_rd = v.ard;  alu_value = v.aval;
    rs1 = v.r1;  rs2 = v.r2;
    @(posedge clock); #1;
    mem_valid = 1'b0;  alu_valid = 1'b0;
    #1;
    chk($sformatf("v%0d.write_to_rd", k), 32'(write_to_rd), 32'(v.e_wr));
    chk($sformatf("v%0d.rd", k), 32'(rd), 32'(v.e_rd));
    chk($sformatf("v%0d.rd_value", k), rd_value, v.e_val);
    chk($sformatf("v%0d.count", k), 32'(count), 32'(v.e_cnt));
    chk($sformatf("v%0d.mem_ready", k), 32'(mem_ready), 32'(v.e_cnt < 3'd4));
    chk($sformatf("v%0d.alu_ready", k), 32'(alu_ready), 32'(v.e_cnt <= 3'd2));
    chk($sformatf("v%0d.rs1_hit", k), 32'(rs1_hit), 32'(v.e_h1));
    chk($sformatf("v%0d.rs1_fwd", k), rs1_fwd, v.e_f1);
    chk($sformatf("v%0d.rs2_hit", k), 32'(rs2_hit), 32'(v.e_h2));
    chk($sformatf("v%0d.rs2_fwd", k), rs2_fwd, v.e_f2);
  endtask

  initial begin
    logic [4:0]  q_rd [$];
    logic [31:0] q_val [$];
    int          exp_seq [6];
    logic        pm;
    logic        pa;

    //            mv   mrd    mval          av   ard    aval          r1     r2     wr   rd     val           cnt   h1   f1            h2   f2
    tbl[0] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h1234,     5'd5, 5'd0, 1'b1, 5'd5, 32'h1234,     3'd1, 1'b1, 32'h1234,     1'b0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[2] = '{1'b1, 5'd3, 32'hAAAA0001, 1'b1, 5'd3, 32'hBBBB0002, 5'd3, 5'd7, 1'b1, 5'd3, 32'hAAAA0001, 3'd2, 1'b1, 32'hBBBB0002, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b1, 5'd3, 32'hBBBB0002, 3'd1, 1'b1, 32'hBBBB0002, 1'b1, 32'hBBBB0002};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[6] = '{1'b1, 5'd0, 32'hDEAD,     1'b1, 5'd9, 32'h99,       5'd9, 5'd0, 1'b1, 5'd9, 32'h99,       3'd1, 1'b1, 32'h99,       1'b0, 32'h0};
    tbl[7] = '{1'b1, 5'd6, 32'h66,       1'b1, 5'd7, 32'h77,       5'd6, 5'd7, 1'b1, 5'd6, 32'h66,       3'd2, 1'b1, 32'h66,       1'b1, 32'h77};
    tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd6, 5'd7, 1'b1, 5'd7, 32'h77,       3'd1, 1'b0, 32'h0,        1'b1, 32'h77};
    tbl[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd6, 5'd7, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
    exp_seq = '{2, 3, 3, 3, 3, 3};

    reset = 1'b1;
    mem_valid = 1'b0;  mem_rd = '0;  mem_value = '0;
    alu_valid = 1'b0;  alu_rd = '0;  alu_value = '0;
    rs1 = '0;  rs2 = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.mem_ready", 32'(mem_ready), 32'd0);
    chk("rst.alu_ready", 32'(alu_ready), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.write_to_rd", 32'(write_to_rd), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.mem_ready", 32'(mem_ready), 32'd1);
    chk("post_rst.alu_ready", 32'(alu_ready), 32'd1);

    // x0 discard: ALU still reports ready before the edge
    chk("x0.alu_ready_pre", 32'(alu_ready), 32'd1);

    for (int k = 0; k < 10; k++) apply(tbl[k], k);

    // Back-pressure: both sources valid every cycle
    for (int k = 0; k < 6; k++) begin
      mem_valid = 1'b1;  mem_rd = 5'(2 * k + 1);  mem_value = 32'hA000_0000 + 32'(k);
      alu_valid = 1'b1;  alu_rd = 5'(2 * k + 2);  alu_value = 32'hB000_0000 + 32'(k);
      #1;
      pm = (q_rd.size() < 4);
      pa = (q_rd.size() <= 2);
      chk($sformatf("bp%0d.mem_ready", k), 32'(mem_ready), 32'(pm));
      chk($sformatf("bp%0d.alu_ready", k), 32'(alu_ready), 32'(pa));
      @(posedge clock); #1;
      if (q_rd.size() > 0) begin
        void'(q_rd.pop_front());
        void'(q_val.pop_front());
      end
      if (pm) begin q_rd.push_back(mem_rd); q_val.push_back(mem_value); end
      if (pa) begin q_rd.push_back(alu_rd); q_val.push_back(alu_value); end
      chk($sformatf("bp%0d.count", k), 32'(count), 32'(exp_seq[k]));
      chk($sformatf("bp%0d.write_to_rd", k), 32'(write_to_rd), 32'd1);
      chk($sformatf("bp%0d.rd", k), 32'(rd), 32'(q_rd[0]));
      chk($sformatf("bp%0d.rd_value", k), rd_value, q_val[0]);
    end
    mem_valid = 1'b0;  alu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      if (q_rd.size() > 0) begin
        void'(q_rd.pop_front());
        void'(q_val.pop_front());
      end
      chk($sformatf("drain%0d.count", k), 32'(count), 32'(q_rd.size()));
      chk($sformatf("drain%0d.write_to_rd", k), 32'(write_to_rd), 32'(q_rd.size() != 0));
      if (q_rd.size() > 0) begin
        chk($sformatf("drain%0d.rd", k), 32'(rd), 32'(q_rd[0]));
        chk($sformatf("drain%0d.rd_value", k), rd_value, q_val[0]);
      end
    end

    // Reset mid-operation with three entries pending
    mem_valid = 1'b1;  mem_rd = 5'd11;  mem_value = 32'h1100;
    alu_valid = 1'b1;  alu_rd = 5'd12;  alu_value = 32'h1200;
    @(posedge clock); #1;
    mem_rd = 5'd13;  mem_value = 32'h1300;
    alu_rd = 5'd14;  alu_value = 32'h1400;
    @(posedge clock); #1;
    mem_valid = 1'b0;  alu_valid = 1'b0;
    rs1 = 5'd13;  rs2 = 5'd14;
    #1;
    chk("mid.count", 32'(count), 32'd3);
    chk("mid.rs1_fwd", rs1_fwd, 32'h1300);
    chk("mid.rs2_fwd", rs2_fwd, 32'h1400);
    reset = 1'b1;
    mem_valid = 1'b1;  mem_rd = 5'd15;  mem_value = 32'h1500;
    alu_valid = 1'b1;  alu_rd = 5'd16;  alu_value = 32'h1600;
    #1;
    chk("mid_rst.mem_ready", 32'(mem_ready), 32'd0);
    chk("mid_rst.alu_ready", 32'(alu_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    mem_valid = 1'b0;  alu_valid = 1'b0;
    #1;
    chk("after_rst.count", 32'(count), 32'd0);
    chk("after_rst.write_to_rd", 32'(write_to_rd), 32'd0);
    chk("after_rst.rs1_hit", 32'(rs1_hit), 32'd0);
    chk("after_rst.rs2_hit", 32'(rs2_hit), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk($sformatf("after_rst%0d.write_to_rd", k), 32'(write_to_rd), 32'd0);
    end

    // Wrap-around: ten back-to-back ALU pushes
    rs1 = '0;  rs2 = '0;
    for (int i = 1; i <= 10; i++) begin
      alu_valid = 1'b1;  alu_rd = 5'(i);  alu_value = 32'(i * 16);
      #1;
      chk($sformatf("wrap%0d.alu_ready", i), 32'(alu_ready), 32'd1);
      @(posedge clock); #1;
      chk($sformatf("wrap%0d.write_to_rd", i), 32'(write_to_rd), 32'd1);
      chk($sformatf("wrap%0d.rd", i), 32'(rd), 32'(i));
      chk($sformatf("wrap%0d.rd_value", i), rd_value, 32'(i * 16));
      chk($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
    end
    alu_valid = 1'b0;
    @(posedge clock); #1;
    chk("wrap_end.write_to_rd", 32'(write_to_rd), 32'd0);
    chk("wrap_end.count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
